// File: rtl/riscv_soft_pkg.sv
// Shared types and constants for the soft RISC-V writeback stage.
// Load-extension helper used by the writeback datapath.
package riscv_soft_pkg;

  localparam int XPR_LEN    = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [1:0]            off;
  } ld_entry_t;

  // Align the addressed byte/half to bit 0, then sign- or zero-extend.
  function automatic logic [XPR_LEN-1:0] load_extend(input logic [2:0] funct3,
                                                      input logic [1:0] off,
                                                      input logic [XPR_LEN-1:0] raw);
    logic [XPR_LEN-1:0] shifted;
    shifted = raw >> {off, 3'b000};
    case (funct3)
      F3_LB:   load_extend = {{(XPR_LEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_extend = {{(XPR_LEN-8){1'b0}}, shifted[7:0]};
      F3_LH:   load_extend = {{(XPR_LEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_extend = {{(XPR_LEN-16){1'b0}}, shifted[15:0]};
      default: load_extend = shifted;
    endcase
  endfunction

endpackage

// File: rtl/riscv_soft_ld_queue.sv
// In-order queue of outstanding loads (rd, funct3, byte offset).
// Circular buffer with wrap-around pointers and an explicit fill count.
module riscv_soft_ld_queue
  import riscv_soft_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  ld_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output ld_entry_t             head,
  output ld_entry_t [DEPTH-1:0] entries,
  output logic      [DEPTH-1:0] valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  ld_entry_t        mem_reg [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] rel;
      assign rel          = PTR_W'(gi) - rd_ptr_reg;
      assign valid[gi]    = ({1'b0, rel} < count_reg);
      assign entries[gi]  = mem_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/riscv_soft_writeback.sv
// Writeback stage: merges load responses and ALU results onto the regfile write port.
// Define RISCV_SOFT_WB_SCOREBOARD_EN to add the pend_mask hazard output.
module riscv_soft_writeback
  import riscv_soft_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XPR_LEN-1:0]    alu_data,
  input  logic                  ld_issue_valid,
  output logic                  ld_issue_ready,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic [2:0]            ld_issue_funct3,
  input  logic [1:0]            ld_issue_off,
  input  logic                  dmem_resp_valid,
  input  logic [XPR_LEN-1:0]    dmem_resp_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XPR_LEN-1:0]    wr_data,
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
  output logic [NUM_REGS-1:0]   pend_mask,
`endif
  output logic                  err_unexp_resp
);

  logic                  hold_valid_reg;
  logic [REG_ADDR_W-1:0] hold_rd_reg;
  logic [XPR_LEN-1:0]    hold_data_reg;
  logic                  wr_en_reg;
  logic [REG_ADDR_W-1:0] wr_addr_reg;
  logic [XPR_LEN-1:0]    wr_data_reg;
  logic                  err_reg;

  logic                     q_full;
  logic                     q_empty;
  ld_entry_t                q_head;
  ld_entry_t [LD_DEPTH-1:0] q_entries;
  logic      [LD_DEPTH-1:0] q_valid;

  logic                  alu_fire;
  logic                  ld_push;
  logic                  ld_pop;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XPR_LEN-1:0]    sel_data;
  logic                  wr_en_next;

  assign alu_ready      = !hold_valid_reg;
  assign ld_issue_ready = !q_full;
  assign alu_fire       = alu_valid && alu_ready;
  assign ld_push        = ld_issue_valid && ld_issue_ready;
  assign ld_pop         = dmem_resp_valid && !q_empty;

  riscv_soft_ld_queue #(
    .DEPTH(LD_DEPTH)
  ) u_ld_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (ld_push),
    .push_entry ('{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off}),
    .pop        (ld_pop),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head),
    .entries    (q_entries),
    .valid      (q_valid)
  );

  // A load response owns the write port even when it is unexpected and writes nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (dmem_resp_valid) begin
      sel_valid = !q_empty;
      sel_rd    = q_head.rd;
      sel_data  = load_extend(q_head.funct3, q_head.off, dmem_resp_data);
    end else if (hold_valid_reg) begin
      sel_valid = 1'b1;
      sel_rd    = hold_rd_reg;
      sel_data  = hold_data_reg;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
  end

  assign wr_en_next = sel_valid && (sel_rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_reg <= 1'b0;
      hold_rd_reg    <= '0;
      hold_data_reg  <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      wr_en_reg <= wr_en_next;
      if (wr_en_next) begin
        wr_addr_reg <= sel_rd;
        wr_data_reg <= sel_data;
      end
      if (dmem_resp_valid && q_empty) err_reg <= 1'b1;
      if (dmem_resp_valid && alu_fire) begin
        hold_valid_reg <= 1'b1;
        hold_rd_reg    <= alu_rd;
        hold_data_reg  <= alu_data;
      end else if (!dmem_resp_valid && hold_valid_reg) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  assign wr_en          = wr_en_reg;
  assign wr_addr        = wr_addr_reg;
  assign wr_data        = wr_data_reg;
  assign err_unexp_resp = err_reg;

`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_mask[gi] = 1'b0;
      end else begin : g_reg
        logic hit;
        always_comb begin
          hit = hold_valid_reg && (hold_rd_reg == REG_ADDR_W'(gi));
          for (int j = 0; j < LD_DEPTH; j++) begin
            hit = hit || (q_valid[j] && (q_entries[j].rd == REG_ADDR_W'(gi)));
          end
        end
        assign pend_mask[gi] = hit;
      end
    end
  endgenerate
`else
  logic unused_q_state;
  assign unused_q_state = ^{q_entries, q_valid};
`endif

endmodule

// File: tb/tb_riscv_soft_writeback.sv
// Self-checking bench for riscv_soft_writeback: directed cases plus a randomized run
// against a queue-based reference model. Honours RISCV_SOFT_WB_SCOREBOARD_EN.
module tb_riscv_soft_writeback;
  import riscv_soft_pkg::*;

  localparam int LD_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  alu_valid = 1'b0;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd = '0;
  logic [XPR_LEN-1:0]    alu_data = '0;
  logic                  ld_issue_valid = 1'b0;
  logic                  ld_issue_ready;
  logic [REG_ADDR_W-1:0] ld_issue_rd = '0;
  logic [2:0]            ld_issue_funct3 = '0;
  logic [1:0]            ld_issue_off = '0;
  logic                  dmem_resp_valid = 1'b0;
  logic [XPR_LEN-1:0]    dmem_resp_data = '0;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XPR_LEN-1:0]    wr_data;
  logic                  err_unexp_resp;
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0]   pend_mask;
`endif

  riscv_soft_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_issue_valid  (ld_issue_valid),
    .ld_issue_ready  (ld_issue_ready),
    .ld_issue_rd     (ld_issue_rd),
    .ld_issue_funct3 (ld_issue_funct3),
    .ld_issue_off    (ld_issue_off),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
    .pend_mask       (pend_mask),
`endif
    .err_unexp_resp  (err_unexp_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    int unsigned rd;
    int unsigned f3;
    int unsigned off;
  } ent_t;
  ent_t        mq[$];
  bit          m_hold_v = 0;
  int unsigned m_hold_rd = 0;
  int unsigned m_hold_d = 0;
  bit          m_wr_en = 0;
  int unsigned m_wr_addr = 0;
  int unsigned m_wr_data = 0;
  bit          m_err = 0;

  int unsigned f3_tab [6] = '{0, 1, 2, 4, 5, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ext(input int unsigned f3, input int unsigned off,
                                      input int unsigned d);
    int unsigned v;
    v = d / (1 << (8 * off));
    case (f3)
      0: return ((v % 256) ^ 32'h80) - 32'h80;
      4: return v % 256;
      1: return ((v % 65536) ^ 32'h8000) - 32'h8000;
      5: return v % 65536;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) if (mq[i].rd != 0) p[mq[i].rd] = 1'b1;
    if (m_hold_v && m_hold_rd != 0) p[m_hold_rd] = 1'b1;
    return p;
  endfunction

  task automatic m_write(input int unsigned rd, input int unsigned d);
    if (rd != 0) begin
      m_wr_en   = 1;
      m_wr_addr = rd;
      m_wr_data = d;
    end
  endtask

  task automatic idle();
    alu_valid       = 1'b0;
    ld_issue_valid  = 1'b0;
    dmem_resp_valid = 1'b0;
  endtask

  // Inputs are set by the caller; check readiness, advance the model, clock, check outputs.
  task automatic cycle();
    bit   alu_t, ld_t;
    ent_t e;
    #1;
    chk("alu_ready", alu_ready, !m_hold_v);
    chk("ld_issue_ready", ld_issue_ready, mq.size() < LD_DEPTH);
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
    chk("pend_mask", pend_mask, m_pend());
`endif
    alu_t   = alu_valid && !m_hold_v;
    ld_t    = ld_issue_valid && (mq.size() < LD_DEPTH);
    m_wr_en = 0;
    if (dmem_resp_valid) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_write(e.rd, ext(e.f3, e.off, dmem_resp_data));
      end else begin
        m_err = 1;
      end
      if (alu_t) begin
        m_hold_v  = 1;
        m_hold_rd = alu_rd;
        m_hold_d  = alu_data;
      end
    end else if (m_hold_v) begin
      m_write(m_hold_rd, m_hold_d);
      m_hold_v = 0;
    end else if (alu_t) begin
      m_write(alu_rd, alu_data);
    end
    if (ld_t) mq.push_back('{rd: ld_issue_rd, f3: ld_issue_funct3, off: ld_issue_off});
    @(posedge clk);
    #1;
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_addr", wr_addr, m_wr_addr);
    chk("wr_data", wr_data, m_wr_data);
    chk("err_unexp_resp", err_unexp_resp, m_err);
    $display("cyc t=%0t wr_en=%0b wr_addr=%0d wr_data=%08h err=%0b qlen=%0d hold=%0b",
             $time, wr_en, wr_addr, wr_data, err_unexp_resp, mq.size(), m_hold_v);
    idle();
  endtask

  task automatic issue(input int unsigned rd, input int unsigned f3, input int unsigned off);
    ld_issue_valid  = 1'b1;
    ld_issue_rd     = rd[4:0];
    ld_issue_funct3 = f3[2:0];
    ld_issue_off    = off[1:0];
  endtask

  task automatic alu(input int unsigned rd, input int unsigned d);
    alu_valid = 1'b1;
    alu_rd    = rd[4:0];
    alu_data  = d;
  endtask

  task automatic resp(input int unsigned d);
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mq.delete();
    m_hold_v = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_err = 0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_err", err_unexp_resp, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_ld_ready", ld_issue_ready, 1'b1);
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
    chk("rst_pend_mask", pend_mask, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("reset released t=%0t", $time);
  endtask

  initial begin
    idle();
    #2;
    do_reset();

    // 1: ALU only, latency 1
    alu(5, 32'h1234); cycle();
    chk("t1_wr_en", wr_en, 1'b1);
    chk("t1_wr_addr", wr_addr, 5'd5);
    chk("t1_wr_data", wr_data, 32'h1234);
    cycle();

    // 2: load extension vectors
    issue(9, 0, 2); cycle();
    resp(32'h0080_0000); cycle();
    chk("t2_lb", wr_data, 32'hFFFF_FF80);
    issue(10, 5, 2); cycle();
    resp(32'h8001_0000); cycle();
    chk("t2_lhu", wr_data, 32'h0000_8001);

    // 3: collision, load wins and ALU result is held
    issue(7, 2, 0); cycle();
    alu(3, 32'hCAFE_0003); resp(32'hDEAD_0007); cycle();
    chk("t3_first_addr", wr_addr, 5'd7);
    chk("t3_alu_ready", alu_ready, 1'b0);
    cycle();
    chk("t3_second_addr", wr_addr, 5'd3);
    chk("t3_second_data", wr_data, 32'hCAFE_0003);

    // 4: fill the queue, then drain with push+pop across pointer wrap
    for (int i = 0; i < LD_DEPTH; i++) begin
      issue(11 + i, 2, 0); cycle();
    end
    chk("t4_full", ld_issue_ready, 1'b0);
    issue(20, 2, 0); resp(32'h1111_0011); cycle();
    chk("t4_pop_addr", wr_addr, 5'd11);
    issue(15, 4, 3); resp(32'h2222_0012); cycle();
    chk("t4_pushpop_addr", wr_addr, 5'd12);
    for (int i = 0; i < 3; i++) begin
      resp(32'hA5A5_5A00 + i); cycle();
    end
    chk("t4_last_addr", wr_addr, 5'd15);
    chk("t4_last_data", wr_data, 32'h0000_00A5);

    // 5: unexpected response, rd=0 ALU
    resp(32'hFFFF_FFFF); cycle();
    chk("t5_no_write", wr_en, 1'b0);
    chk("t5_err", err_unexp_resp, 1'b1);
    cycle();
    chk("t5_err_held", err_unexp_resp, 1'b1);
    alu(0, 32'h5555_5555); cycle();
    chk("t5_rd0_wr_en", wr_en, 1'b0);
    chk("t5_rd0_ready", alu_ready, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned f3, off;
      if ($urandom_range(0, 1) == 1)
        alu(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), $urandom);
      if ($urandom_range(0, 2) != 0) begin
        f3 = f3_tab[$urandom_range(0, 5)];
        case (f3)
          0, 4:    off = $urandom_range(0, 3);
          1, 5:    off = 2 * $urandom_range(0, 1);
          default: off = 0;
        endcase
        issue(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), f3, off);
      end
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) resp($urandom);
      cycle();
    end

    // 6: reset mid-stream with loads queued and hold valid
    issue(21, 2, 0); cycle();
    while (mq.size() > 0 || m_hold_v) begin
      if (mq.size() > 0) resp($urandom);
      cycle();
    end
    issue(22, 2, 0); cycle();
    issue(23, 2, 0); cycle();
    issue(24, 2, 0); cycle();
    alu(25, 32'h0000_0025); resp(32'h0000_0021); cycle();
    chk("t6_hold_set", alu_ready, 1'b0);
    chk("t6_qlen", ld_issue_ready, 1'b1);
    #2;
    do_reset();
    resp(32'h0BAD_0BAD); cycle();
    chk("t6_flushed_err", err_unexp_resp, 1'b1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
